// File: rtl/xlmc_ddr_lane_bank.sv
// SDR-side sequencer for a bank of bidirectional DDR DQ pads: write serialisation, turnaround, read capture.
// Optional internal loopback path is enabled by defining XLMC_LANE_BANK_LOOPBACK_EN.
module xlmc_ddr_lane_bank #(
    parameter int LANES       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int LEN_W       = 8
) (
    input  logic                 oddr_clk,
    input  logic                 arst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [2*LANES-1:0]   tx_data,
    input  logic                 tx_last,
    input  logic [LEN_W-1:0]     rd_len,
    input  logic [4:0]           rd_lat,
`ifdef XLMC_LANE_BANK_LOOPBACK_EN
    input  logic                 lpbk_en,
`endif
    output logic [2*LANES-1:0]   pad_sdr_o,
    output logic                 pad_t,
    input  logic [2*LANES-1:0]   pad_sdr_i,
    output logic [2*LANES-1:0]   rx_data,
    output logic                 rx_valid,
    output logic                 rx_last,
    output logic                 busy
);

    localparam int W     = 2 * LANES;
    // Wide enough for any 5-bit rd_lat and for TURN_CYCLES itself (TURN_CYCLES must be >= 1).
    localparam int CNT_W = $clog2(TURN_CYCLES + 32);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_TX   = 2'b01,
        ST_TURN = 2'b10,
        ST_RX   = 2'b11
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [W-1:0]       pad_o_r, pad_o_nxt_s;
    logic               pad_t_r, pad_t_nxt_s;
    logic [W-1:0]       rx_data_r, rx_data_nxt_s;
    logic               rx_valid_r, rx_valid_nxt_s;
    logic               rx_last_r, rx_last_nxt_s;
    logic [CNT_W-1:0]   turn_r, turn_nxt_s;
    logic [LEN_W-1:0]   beat_r, beat_nxt_s;
    logic               lpbk_r, lpbk_nxt_s;
    logic               lpbk_in_s;
    logic               accept_s;
    logic [CNT_W-1:0]   lat_s;
    logic [CNT_W-1:0]   turn_load_s;

`ifdef XLMC_LANE_BANK_LOOPBACK_EN
    assign lpbk_in_s = lpbk_en;
`else
    assign lpbk_in_s = 1'b0;
`endif

    assign tx_ready    = (state_r == ST_IDLE) || (state_r == ST_TX);
    assign busy        = (state_r != ST_IDLE);
    assign accept_s    = tx_valid && tx_ready;
    // Turnaround length is the larger of the requested dummy cycles and the bus minimum.
    assign lat_s       = (CNT_W'(rd_lat) > CNT_W'(TURN_CYCLES)) ? CNT_W'(rd_lat) : CNT_W'(TURN_CYCLES);
    assign turn_load_s = lat_s - CNT_W'(1);

    assign pad_sdr_o = pad_o_r;
    assign pad_t     = pad_t_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign rx_last   = rx_last_r;

    // Next-state and next-register-value logic.
    always_comb begin
        state_nxt_s    = state_r;
        pad_o_nxt_s    = pad_o_r;
        pad_t_nxt_s    = pad_t_r;
        rx_data_nxt_s  = rx_data_r;
        rx_valid_nxt_s = 1'b0;
        rx_last_nxt_s  = 1'b0;
        turn_nxt_s     = turn_r;
        beat_nxt_s     = beat_r;
        lpbk_nxt_s     = lpbk_r;
        case (state_r)
            ST_IDLE, ST_TX: begin
                if (accept_s) begin
                    pad_o_nxt_s = tx_data;
                    if (state_r == ST_IDLE) begin
                        lpbk_nxt_s  = lpbk_in_s;
                        pad_t_nxt_s = lpbk_in_s;
                    end else begin
                        pad_t_nxt_s = pad_t_r;
                    end
                    if (tx_last) begin
                        if (rd_len == {LEN_W{1'b0}}) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_TURN;
                            turn_nxt_s  = turn_load_s;
                            beat_nxt_s  = rd_len;
                        end
                    end else begin
                        state_nxt_s = ST_TX;
                    end
                end else if (state_r == ST_IDLE) begin
                    // Release the bus one cycle after a write-only transaction ends.
                    pad_t_nxt_s = 1'b1;
                end else begin
                    pad_t_nxt_s = pad_t_r;
                end
            end
            ST_TURN: begin
                pad_t_nxt_s = 1'b1;
                if (turn_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_RX;
                end else begin
                    turn_nxt_s = turn_r - CNT_W'(1);
                end
            end
            ST_RX: begin
                pad_t_nxt_s    = 1'b1;
                rx_data_nxt_s  = lpbk_r ? pad_o_r : pad_sdr_i;
                rx_valid_nxt_s = 1'b1;
                beat_nxt_s     = beat_r - LEN_W'(1);
                if (beat_r == LEN_W'(1)) begin
                    rx_last_nxt_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    rx_last_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pad_t_nxt_s = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge oddr_clk) begin
        if (arst) begin
            state_r    <= ST_IDLE;
            pad_o_r    <= {W{1'b0}};
            pad_t_r    <= 1'b1;
            rx_data_r  <= {W{1'b0}};
            rx_valid_r <= 1'b0;
            rx_last_r  <= 1'b0;
            turn_r     <= {CNT_W{1'b0}};
            beat_r     <= {LEN_W{1'b0}};
            lpbk_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pad_o_r    <= pad_o_nxt_s;
            pad_t_r    <= pad_t_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rx_valid_r <= rx_valid_nxt_s;
            rx_last_r  <= rx_last_nxt_s;
            turn_r     <= turn_nxt_s;
            beat_r     <= beat_nxt_s;
            lpbk_r     <= lpbk_nxt_s;
        end
    end

endmodule

// File: tb/tb_xlmc_ddr_lane_bank.sv
// Self-checking bench for xlmc_ddr_lane_bank: directed and randomized transactions against a timeline model.
module tb_xlmc_ddr_lane_bank;

    localparam int LANES = 8;
    localparam int TC    = 2;
    localparam int LEN_W = 8;
    localparam int W     = 2 * LANES;

    logic             clk = 1'b0;
    logic             arst;
    logic             tx_valid;
    logic             tx_ready;
    logic [W-1:0]     tx_data;
    logic             tx_last;
    logic [LEN_W-1:0] rd_len;
    logic [4:0]       rd_lat;
`ifdef XLMC_LANE_BANK_LOOPBACK_EN
    logic             lpbk_en;
`endif
    logic [W-1:0]     pad_sdr_o;
    logic             pad_t;
    logic [W-1:0]     pad_sdr_i;
    logic [W-1:0]     rx_data;
    logic             rx_valid;
    logic             rx_last;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] beats_q[$];

    always #5 clk = ~clk;

    xlmc_ddr_lane_bank #(.LANES(LANES), .TURN_CYCLES(TC), .LEN_W(LEN_W)) dut (
        .oddr_clk (clk),
        .arst     (arst),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .rd_len   (rd_len),
        .rd_lat   (rd_lat),
`ifdef XLMC_LANE_BANK_LOOPBACK_EN
        .lpbk_en  (lpbk_en),
`endif
        .pad_sdr_o(pad_sdr_o),
        .pad_t    (pad_t),
        .pad_sdr_i(pad_sdr_i),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_last  (rx_last),
        .busy     (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Drives beats_q as one transaction and checks every cycle against the expected timeline:
    // last beat at E0, N = max(rd_lat, TC), read beats after E0+N+1 .. E0+N+rl.
    task automatic run_txn(input int rl, input int rlat, input bit bub, input bit idx_mode,
                           input bit lp, input bit poke);
        int nb;
        int n;
        logic [W-1:0] last_b;
        logic [W-1:0] v;
        nb = beats_q.size();
        n  = (rlat > TC) ? rlat : TC;
        for (int i = 0; i < nb; i++) begin
            if (i > 0 && bub && $urandom_range(0, 1) == 1) begin
                tx_valid = 1'b0;
                tx_data  = W'($urandom);
                step();
                chk_w("bubble_hold", pad_sdr_o, beats_q[i-1]);
                chk_b("bubble_t", pad_t, lp);
            end
            chk_b("tx_ready_wr", tx_ready, 1'b1);
            tx_valid = 1'b1;
            tx_data  = beats_q[i];
            tx_last  = (i == nb - 1);
            rd_len   = LEN_W'(rl);
            rd_lat   = 5'(rlat);
`ifdef XLMC_LANE_BANK_LOOPBACK_EN
            lpbk_en  = (i == 0) ? lp : 1'($urandom);
`endif
            step();
            chk_w("beat_out", pad_sdr_o, beats_q[i]);
            chk_b("beat_t", pad_t, lp);
            chk_b("busy_wr", busy, (i != nb - 1) || (rl != 0));
        end
        last_b   = beats_q[nb-1];
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        rd_len   = LEN_W'($urandom);
        rd_lat   = 5'($urandom);
        if (rl == 0) begin
            step();
            chk_b("wo_t", pad_t, 1'b1);
            chk_b("wo_busy", busy, 1'b0);
            chk_w("wo_hold", pad_sdr_o, last_b);
            chk_b("wo_rxv", rx_valid, 1'b0);
        end else begin
            for (int k = 1; k <= n; k++) begin
                chk_b("turn_ready", tx_ready, 1'b0);
                tx_valid  = poke ? 1'($urandom) : 1'b0;
                tx_data   = W'($urandom);
                tx_last   = 1'($urandom);
                pad_sdr_i = W'($urandom);
                step();
                chk_b("turn_t", pad_t, 1'b1);
                chk_b("turn_rxv", rx_valid, 1'b0);
                chk_b("turn_busy", busy, 1'b1);
                chk_w("turn_hold", pad_sdr_o, last_b);
            end
            for (int j = 0; j < rl; j++) begin
                v = idx_mode ? W'(j) : W'($urandom);
                chk_b("rx_ready", tx_ready, 1'b0);
                pad_sdr_i = v;
                tx_valid  = poke ? 1'($urandom) : 1'b0;
                tx_data   = W'($urandom);
                step();
                chk_b("rx_valid", rx_valid, 1'b1);
                chk_w("rx_data", rx_data, lp ? last_b : v);
                chk_b("rx_last", rx_last, j == rl - 1);
                chk_b("rx_t", pad_t, 1'b1);
                chk_w("rx_hold", pad_sdr_o, last_b);
            end
            tx_valid = 1'b0;
            tx_last  = 1'b0;
            step();
            chk_b("end_rxv", rx_valid, 1'b0);
            chk_b("end_rxl", rx_last, 1'b0);
            chk_b("end_busy", busy, 1'b0);
            chk_b("end_ready", tx_ready, 1'b1);
            chk_b("end_t", pad_t, 1'b1);
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    initial begin
        int nb;
        arst      = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_last   = 1'b0;
        rd_len    = '0;
        rd_lat    = '0;
        pad_sdr_i = '0;
`ifdef XLMC_LANE_BANK_LOOPBACK_EN
        lpbk_en   = 1'b0;
`endif
        step();
        step();
        chk_b("rst_t", pad_t, 1'b1);
        chk_w("rst_pad", pad_sdr_o, '0);
        chk_w("rst_rxd", rx_data, '0);
        chk_b("rst_rxv", rx_valid, 1'b0);
        chk_b("rst_rxl", rx_last, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_ready", tx_ready, 1'b1);
        arst = 1'b0;
        step();

        // Write-only, four back-to-back beats.
        beats_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        run_txn(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Write then read, dummy latency above the turnaround minimum.
        beats_q = '{16'hA5A5};
        run_txn(3, 5, 1'b0, 1'b1, 1'b0, 1'b0);

        // Latency clamped up to the turnaround minimum, single read beat.
        beats_q = '{16'h3C3C};
        run_txn(1, 0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Bubble in the middle of a write, then writes offered during turnaround/read.
        tx_valid = 1'b1;
        tx_data  = 16'h1111;
        step();
        chk_w("bub_b0", pad_sdr_o, 16'h1111);
        tx_valid = 1'b0;
        tx_data  = 16'hFFFF;
        step();
        chk_w("bub_gap", pad_sdr_o, 16'h1111);
        chk_b("bub_gap_t", pad_t, 1'b0);
        beats_q = '{16'h2222};
        run_txn(2, 3, 1'b0, 1'b0, 1'b0, 1'b1);

        // Maximum burst length.
        beats_q = '{16'h0BAD};
        run_txn(255, 1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized transactions.
        for (int t = 0; t < 25; t++) begin
            nb = $urandom_range(1, 4);
            beats_q.delete();
            for (int b = 0; b < nb; b++) beats_q.push_back(W'($urandom));
            run_txn($urandom_range(0, 6), $urandom_range(0, 9), 1'b1, 1'b0, 1'b0, 1'b1);
        end

`ifdef XLMC_LANE_BANK_LOOPBACK_EN
        beats_q = '{16'h0F0F};
        run_txn(1, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        lpbk_en = 1'b0;
`endif

        // Reset held for three cycles in the middle of a read burst.
        tx_valid = 1'b1;
        tx_data  = 16'h7E7E;
        tx_last  = 1'b1;
        rd_len   = 8'd10;
        rd_lat   = 5'd3;
        step();
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk_b("pre_rst_rxv", rx_valid, 1'b1);
        arst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_b("mid_rst_t", pad_t, 1'b1);
            chk_b("mid_rst_rxv", rx_valid, 1'b0);
            chk_w("mid_rst_pad", pad_sdr_o, '0);
            chk_w("mid_rst_rxd", rx_data, '0);
        end
        arst = 1'b0;
        step();
        chk_b("post_rst_t", pad_t, 1'b1);
        chk_b("post_rst_rxv", rx_valid, 1'b0);
        chk_b("post_rst_busy", busy, 1'b0);
        chk_b("post_rst_ready", tx_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
